timer_ctrl: RTL and testbench

Programmable timer controller that sequences an N-bit up-counter datapath through start/stop/pause/restart commands. It supports one-shot and periodic modes. It latches a period value at start and emits a one-cycle `tick` each time the count reaches that period. It sits between the FSM or user logic that issues commands and the counter. Typical uses are generating periodic enables such as baud, debounce and refresh ticks, or one-shot delays.

---
 rtl/timer_ctrl_pkg.sv | 14 +
 rtl/timer_ctrl_if.sv | 25 ++
 rtl/timer_ctrl_counter_ld.sv | 23 ++
 rtl/timer_ctrl.sv | 105 ++++++++++
 tb/tb_timer_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/timer_ctrl_pkg.sv
// Shared state encodings and mode constants for the programmable timer.
// Imported by the timer FSM and anything that decodes its state.
package timer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/timer_ctrl_if.sv
// Command/status bundle between a command issuer (master) and the timer (slave).
// Commands are single-cycle pulses; status is registered or decoded from registers.
interface timer_ctrl_if #(parameter int N = 8);

  logic         start;
  logic         stop;
  logic         pause;
  logic         mode;
  logic [N-1:0] period;
  logic [N-1:0] q;
  logic         tick;
  logic         busy;
  logic         paused;

  modport master (
    output start, stop, pause, mode, period,
    input  q, tick, busy, paused
  );

  modport slave (
    input  start, stop, pause, mode, period,
    output q, tick, busy, paused
  );

endinterface

// File: rtl/timer_ctrl_counter_ld.sv
// N-bit up-counter with synchronous clear (priority) and enable.
// Latency: q updates one cycle after clr/en; no backpressure.
module counter_ld #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [N-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Timer FSM: start/stop/pause/restart sequencing of counter_ld, period/mode latch, tick decode.
// Latency: outputs valid one cycle after the causing edge; commands take no backpressure.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  timer_ctrl_if.slave  bus
);

  state_t       state_q, state_d;
  logic [N-1:0] cnt;
  logic [N-1:0] p_lat;
  logic         mode_lat;
  logic         load;
  logic         clr;
  logic         en;
  logic         advance;
  logic         at_term;

  counter_ld #(.N(N)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .en  (en),
    .q   (cnt)
  );

  assign at_term    = (cnt == p_lat);
  assign bus.q      = cnt;
  assign bus.tick   = (state_q == ST_RUN) && at_term;
  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.paused = (state_q == ST_PAUSED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_lat    <= '0;
      mode_lat <= MODE_ONESHOT;
    end else if (load) begin
      p_lat    <= bus.period;
      mode_lat <= bus.mode;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    clr     = 1'b0;
    en      = 1'b0;
    advance = 1'b0;
    if (bus.stop) begin
      state_d = ST_IDLE;
      clr     = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!bus.pause && bus.start) begin
            state_d = ST_RUN;
            load    = 1'b1;
            clr     = 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.pause) begin
            state_d = ST_PAUSED;
          end else if (bus.start) begin
            load = 1'b1;
            clr  = 1'b1;
          end else begin
            advance = 1'b1;
          end
        end
        ST_PAUSED: begin
          // Resume steps the count on the same edge so a pause delays by exactly its length.
          if (!bus.pause && bus.start) begin
            state_d = ST_RUN;
            advance = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (advance) begin
      if (at_term) begin
        clr = 1'b1;
        if (mode_lat == MODE_ONESHOT) begin
          state_d = ST_IDLE;
        end
      end else begin
        en = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl: periodic, one-shot, pause/resume, command priority,
// period boundaries, held start and asynchronous reset.
module tb_timer_ctrl;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  timer_ctrl_if #(.N(8)) bus ();

  timer_ctrl #(.N(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [7:0] p, input logic m);
    bus.period = p;
    bus.mode   = m;
    bus.start  = 1'b1;
    step();
    bus.start  = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0;
    bus.mode = 1'b0;  bus.period = 8'd0;
    step(); step();
    rst = 1'b0;
    step();
    checks++; if (bus.q !== 8'd0) begin errors++; $display("FAIL reset_q: got %0d want 0", bus.q); end
    checks++; if (bus.tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b want 0", bus.tick); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.paused !== 1'b0) begin errors++; $display("FAIL reset_paused: got %b want 0", bus.paused); end
  endtask

  task automatic test_periodic();
    pulse_start(8'd4, 1'b1);
    for (int i = 0; i < 12; i++) begin
      checks++; if (bus.q !== 8'(i % 5)) begin errors++; $display("FAIL per_q[%0d]: got %0d want %0d", i, bus.q, i % 5); end
      checks++; if (bus.tick !== ((i % 5) == 4)) begin errors++; $display("FAIL per_tick[%0d]: got %b want %b", i, bus.tick, (i % 5) == 4); end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL per_busy[%0d]: got %b want 1", i, bus.busy); end
      step();
    end
    pulse_stop();
    checks++; if (bus.busy !== 1'b0 || bus.q !== 8'd0) begin errors++; $display("FAIL per_stop: busy=%b q=%0d want 0/0", bus.busy, bus.q); end
  endtask

  task automatic test_oneshot();
    pulse_start(8'd3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.q !== 8'(i)) begin errors++; $display("FAIL os_q[%0d]: got %0d want %0d", i, bus.q, i); end
      checks++; if (bus.tick !== (i == 3)) begin errors++; $display("FAIL os_tick[%0d]: got %b want %b", i, bus.tick, i == 3); end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL os_busy[%0d]: got %b want 1", i, bus.busy); end
      step();
    end
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.busy !== 1'b0 || bus.tick !== 1'b0 || bus.q !== 8'd0) begin
        errors++; $display("FAIL os_after[%0d]: busy=%b tick=%b q=%0d want 0/0/0", i, bus.busy, bus.tick, bus.q);
      end
      step();
    end
  endtask

  task automatic test_pause_resume();
    pulse_start(8'd9, 1'b1);
    for (int i = 0; i < 5; i++) step();
    checks++; if (bus.q !== 8'd5) begin errors++; $display("FAIL pr_pre: got %0d want 5", bus.q); end
    bus.pause = 1'b1;
    step();
    bus.pause = 1'b0;
    for (int i = 0; i < 7; i++) begin
      checks++; if (bus.q !== 8'd5 || bus.paused !== 1'b1 || bus.tick !== 1'b0 || bus.busy !== 1'b1) begin
        errors++; $display("FAIL pr_hold[%0d]: q=%0d paused=%b tick=%b busy=%b want 5/1/0/1", i, bus.q, bus.paused, bus.tick, bus.busy);
      end
      if (i < 6) step();
    end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (bus.q !== 8'(6 + k) || bus.tick !== (k == 3) || bus.paused !== 1'b0) begin
        errors++; $display("FAIL pr_resume[%0d]: q=%0d tick=%b paused=%b want %0d/%b/0", k, bus.q, bus.tick, bus.paused, 6 + k, k == 3);
      end
      step();
    end
    pulse_stop();
  endtask

  task automatic test_simultaneous();
    pulse_start(8'd9, 1'b1);
    step(); step(); step();
    bus.stop = 1'b1; bus.start = 1'b1;
    step();
    bus.stop = 1'b0; bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.q !== 8'd0) begin errors++; $display("FAIL stop_start: busy=%b q=%0d want 0/0", bus.busy, bus.q); end
    pulse_start(8'd9, 1'b1);
    step(); step();
    bus.pause = 1'b1; bus.start = 1'b1;
    step();
    bus.pause = 1'b0; bus.start = 1'b0;
    checks++; if (bus.paused !== 1'b1 || bus.busy !== 1'b1 || bus.q !== 8'd2) begin
      errors++; $display("FAIL pause_start: paused=%b busy=%b q=%0d want 1/1/2", bus.paused, bus.busy, bus.q);
    end
    pulse_stop();
  endtask

  task automatic test_boundaries();
    pulse_start(8'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.tick !== 1'b1 || bus.q !== 8'd0) begin errors++; $display("FAIL p0_per[%0d]: tick=%b q=%0d want 1/0", i, bus.tick, bus.q); end
      step();
    end
    pulse_stop();
    checks++; if (bus.tick !== 1'b0) begin errors++; $display("FAIL p0_stop: tick=%b want 0", bus.tick); end

    pulse_start(8'd0, 1'b0);
    checks++; if (bus.tick !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL p0_os: tick=%b busy=%b want 1/1", bus.tick, bus.busy); end
    step();
    checks++; if (bus.tick !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL p0_os_end: tick=%b busy=%b want 0/0", bus.tick, bus.busy); end

    pulse_start(8'd255, 1'b1);
    for (int i = 0; i < 254; i++) begin
      checks++; if (bus.tick !== 1'b0) begin errors++; $display("FAIL p255_early[%0d]: tick=%b want 0", i, bus.tick); end
      step();
    end
    checks++; if (bus.q !== 8'd254) begin errors++; $display("FAIL p255_q254: got %0d want 254", bus.q); end
    step();
    checks++; if (bus.q !== 8'd255 || bus.tick !== 1'b1) begin errors++; $display("FAIL p255_term: q=%0d tick=%b want 255/1", bus.q, bus.tick); end
    step();
    checks++; if (bus.q !== 8'd0 || bus.tick !== 1'b0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL p255_wrap: q=%0d tick=%b busy=%b want 0/0/1", bus.q, bus.tick, bus.busy);
    end
    pulse_stop();

    pulse_start(8'd4, 1'b1);
    bus.period = 8'd2;
    bus.mode   = 1'b0;
    for (int i = 0; i < 7; i++) begin
      checks++; if (bus.q !== 8'(i % 5) || bus.tick !== ((i % 5) == 4) || bus.busy !== 1'b1) begin
        errors++; $display("FAIL chg_keep[%0d]: q=%0d tick=%b busy=%b want %0d/%b/1", i, bus.q, bus.tick, bus.busy, i % 5, (i % 5) == 4);
      end
      step();
    end
    pulse_start(8'd2, 1'b1);
    for (int i = 0; i < 6; i++) begin
      checks++; if (bus.q !== 8'(i % 3) || bus.tick !== ((i % 3) == 2)) begin
        errors++; $display("FAIL chg_reload[%0d]: q=%0d tick=%b want %0d/%b", i, bus.q, bus.tick, i % 3, (i % 3) == 2);
      end
      step();
    end
    pulse_stop();
  endtask

  task automatic test_start_held();
    bus.period = 8'd3;
    bus.mode   = 1'b1;
    bus.start  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++; if (bus.q !== 8'd0 || bus.tick !== 1'b0 || bus.busy !== 1'b1) begin
        errors++; $display("FAIL held_start[%0d]: q=%0d tick=%b busy=%b want 0/0/1", i, bus.q, bus.tick, bus.busy);
      end
    end
    bus.start = 1'b0;
    step();
    checks++; if (bus.q !== 8'd1) begin errors++; $display("FAIL held_release: q=%0d want 1", bus.q); end
    pulse_stop();
  endtask

  task automatic test_async_reset();
    pulse_start(8'd9, 1'b1);
    for (int i = 0; i < 6; i++) step();
    checks++; if (bus.q !== 8'd6) begin errors++; $display("FAIL ar_pre: q=%0d want 6", bus.q); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.q !== 8'd0 || bus.busy !== 1'b0 || bus.tick !== 1'b0 || bus.paused !== 1'b0) begin
      errors++; $display("FAIL ar_now: q=%0d busy=%b tick=%b paused=%b want 0/0/0/0", bus.q, bus.busy, bus.tick, bus.paused);
    end
    rst = 1'b0;
    pulse_start(8'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.q !== 8'(i) || bus.tick !== (i == 2) || bus.busy !== 1'b1) begin
        errors++; $display("FAIL ar_restart[%0d]: q=%0d tick=%b busy=%b want %0d/%b/1", i, bus.q, bus.tick, bus.busy, i, i == 2);
      end
      step();
    end
    checks++; if (bus.busy !== 1'b0 || bus.q !== 8'd0) begin errors++; $display("FAIL ar_done: busy=%b q=%0d want 0/0", bus.busy, bus.q); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_periodic();
    test_oneshot();
    test_pause_resume();
    test_simultaneous();
    test_boundaries();
    test_start_held();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
